clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- Multi-channel programmable clock/strobe divider: the parametrised successor of the single fixed 2 Hz divider.
- Generates NCH independent divided square waves plus single-cycle tick strobes from the system clock.
- Each channel's divisor is reprogrammable at runtime without glitches, and each channel has its own enable.
- Sits next to the board clock and feeds display scanning, blink/beep timing and game-tick logic.

Parameters:
- NCH, 4, number of divider channels (1..16).
- CNT_W, 32, width of counters and divisor values.
- DEFAULT_DIV, 12_500_000, reset half-period in clk cycles for every channel (2 Hz output at 50 MHz).
- CH_W, 2, width of cfg_ch; must satisfy 2^CH_W >= NCH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  NCH  per-channel run enable.
- sync_clr  in  1  synchronous phase-realign of all channels.
- cfg_wr  in  1  one-cycle divisor write strobe.
- cfg_ch  in  CH_W  channel index for cfg_wr.
- cfg_div  in  CNT_W  new half-period in clk cycles; must be >= 1.
- clk_out  out  NCH  divided square waves, registered.
- tick  out  NCH  one-clk-wide strobe at each clk_out toggle, registered.
- cfg_err  out  1  one-cycle pulse when a write is rejected.

Behaviour:
- Reset (async, rst=1):
  - cnt[i]=0, clk_out=0, tick=0, cfg_err=0.
  - div_act[i]=div_shd[i]=DEFAULT_DIV, pend[i]=0.
  - All outputs are forced low immediately on rst, independent of clk.
- Per channel, en[i]=1 and no sync_clr:
  - Boundary when cnt[i] >= div_act[i]-1. At a boundary: cnt<=0, clk_out[i] toggles, tick[i]=1 for exactly that one cycle.
  - Otherwise cnt<=cnt+1 and tick[i]=0.
  - Output period = 2*div_act clk cycles, 50% duty. The first toggle after reset occurs div_act cycles after en rises.
- en[i]=0:
  - cnt and clk_out hold their values; tick[i]=0.
  - On re-enable, counting resumes from the held cnt.
- Writes (cfg_wr=1):
  - cfg_div==0 or cfg_ch>=NCH: rejected. Nothing changes and cfg_err=1 on the next cycle.
  - Otherwise div_shd[cfg_ch]<=cfg_div and pend<=1. Writing again before the boundary overwrites the shadow; last write wins.
- Applying a pending divisor:
  - At the channel's next boundary: div_act<=div_shd, pend<=0. The current half-period always completes with the old divisor, so the output never glitches.
  - If en[i]=0 at the cycle after the write, the divisor is applied immediately: div_act<=div_shd, cnt<=0, pend<=0.
  - A valid write coinciding with a boundary on the same channel is applied at that boundary directly (bypass); pend ends at 0.
- sync_clr=1 (highest priority after rst), all channels:
  - cnt<=0, clk_out<=0, tick<=0.
  - Any pending divisor is applied and pend cleared.
  - A cfg_wr in the same cycle is still captured into the shadow and stays pending.
- Boundary conditions:
  - div_act=1 gives clk_out=clk/2 and tick high every enabled cycle.
  - The counter never exceeds div_act-1, because the >= compare guards reloads.
  - Maximum divisor 2^CNT_W-1 with no wrap-around.
  - Channels are fully independent except for shared sync_clr and the cfg bus.

Test Plan:
- Bench DEFAULT_DIV=4, NCH=4, all en=1 after reset -> each clk_out toggles every 4 clk (period 8); tick high 1 cycle at each toggle; first tick at cycle 4 after en.
- Write ch1 div=2 mid-half-period (cnt=1) -> ch1 finishes the current 4-cycle half-period, then toggles every 2 cycles; other channels unchanged.
- Writes: cfg_div=0, and cfg_ch=5 with a 3-bit CH_W bench (NCH=4) -> cfg_err pulses 1 cycle for each; all divisors unchanged.
- en[2]=0 for 10 cycles at cnt=2 -> clk_out[2] frozen and tick[2]=0; after re-enable the next toggle comes 2 cycles later. Write div=3 while disabled -> applied immediately with cnt=0.
- Channels at different phases, pulse sync_clr -> all clk_out=0 and cnt=0 next cycle, then all toggle together 4 cycles later.
- Assert rst asynchronously mid-count -> outputs drop without a clk edge; after release, behaviour matches the first scenario. div=1 channel -> clk_out=clk/2, tick constantly 1.

Source files
------------

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/strobe divider: NCH independent square waves
// plus tick strobes, each with its own enable and glitch-free runtime divisor.
module clk_div_multi #(
   parameter int          NCH         = 4,
   parameter int          CNT_W       = 32,
   parameter int unsigned DEFAULT_DIV = 12_500_000,
   parameter int          CH_W        = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH-1:0]   en,
   input  logic             sync_clr,
   input  logic             cfg_wr,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [CNT_W-1:0] cfg_div,
   output logic [NCH-1:0]   clk_out,
   output logic [NCH-1:0]   tick,
   output logic             cfg_err
);

   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic [CNT_W-1:0] cnt     [NCH];
   logic [CNT_W-1:0] div_act [NCH];
   logic [CNT_W-1:0] div_shd [NCH];
   logic [NCH-1:0]   pend;
   logic [NCH-1:0]   wr_hit;
   logic [NCH-1:0]   bnd;
   logic             wr_bad;
   logic             wr_valid;
   logic [31:0]      ch_ext;

   assign ch_ext   = 32'(cfg_ch);
   assign wr_bad   = cfg_wr && ((cfg_div == '0) || (ch_ext >= 32'(NCH)));
   assign wr_valid = cfg_wr && !wr_bad;

   // div_act is never zero, so div_act-1 cannot underflow
   always_comb begin
      wr_hit = '0;
      bnd    = '0;
      for (int i = 0; i < NCH; i++) begin
         wr_hit[i] = wr_valid && (ch_ext == 32'(i));
         bnd[i]    = en[i] && !sync_clr && (cnt[i] >= (div_act[i] - ONE));
      end
   end

   // New divisors only reach div_act at a boundary, a sync_clr, or while the
   // channel is idle, so a running half-period is never cut short.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            cnt[i]     <= '0;
            div_act[i] <= DIV_RST;
            div_shd[i] <= DIV_RST;
         end
         pend    <= '0;
         clk_out <= '0;
         tick    <= '0;
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= wr_bad;
         for (int i = 0; i < NCH; i++) begin
            if (sync_clr) begin
               cnt[i]     <= '0;
               clk_out[i] <= 1'b0;
               tick[i]    <= 1'b0;
               div_act[i] <= div_shd[i];
               if (wr_hit[i]) begin
                  div_shd[i] <= cfg_div;
                  pend[i]    <= 1'b1;
               end else begin
                  pend[i]    <= 1'b0;
               end
            end else if (!en[i]) begin
               tick[i] <= 1'b0;
               if (pend[i]) begin
                  div_act[i] <= div_shd[i];
                  cnt[i]     <= '0;
               end
               if (wr_hit[i]) begin
                  div_shd[i] <= cfg_div;
                  pend[i]    <= 1'b1;
               end else begin
                  pend[i]    <= 1'b0;
               end
            end else if (bnd[i]) begin
               cnt[i]     <= '0;
               clk_out[i] <= ~clk_out[i];
               tick[i]    <= 1'b1;
               pend[i]    <= 1'b0;
               if (wr_hit[i]) begin
                  div_act[i] <= cfg_div;
                  div_shd[i] <= cfg_div;
               end else begin
                  div_act[i] <= div_shd[i];
               end
            end else begin
               cnt[i]  <= cnt[i] + ONE;
               tick[i] <= 1'b0;
               if (wr_hit[i]) begin
                  div_shd[i] <= cfg_div;
                  pend[i]    <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed scenarios plus randomized traffic, all
// checked against a countdown-style reference model of each channel.
module tb_clk_div_multi;

   logic       clk;
   logic       rst;
   logic [3:0] en;
   logic       sync_clr;
   logic       cfg_wr;
   logic [2:0] cfg_ch;
   logic [7:0] cfg_div;
   logic [3:0] clk_out;
   logic [3:0] tick;
   logic       cfg_err;

   int total = 0;
   int bad   = 0;

   // Reference model: cycles left in the current half-period, active
   // half-period, and an optional queued half-period per channel.
   int         left [4];
   int         half [4];
   int         nxt  [4];
   bit         has  [4];
   logic [3:0] m_out;
   logic [3:0] m_tick;
   logic       m_err;

   clk_div_multi #(
      .NCH(4), .CNT_W(8), .DEFAULT_DIV(4), .CH_W(3)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr),
      .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
      .clk_out(clk_out), .tick(tick), .cfg_err(cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         left[i] = 4;
         half[i] = 4;
         nxt[i]  = 4;
         has[i]  = 1'b0;
      end
      m_out  = '0;
      m_tick = '0;
      m_err  = 1'b0;
   endtask

   task automatic model_update();
      bit hit;
      m_err = cfg_wr && ((cfg_div == 0) || (cfg_ch >= 4));
      for (int i = 0; i < 4; i++) begin
         hit       = cfg_wr && (cfg_div != 0) && (int'(cfg_ch) == i);
         m_tick[i] = 1'b0;
         if (sync_clr) begin
            m_out[i] = 1'b0;
            if (has[i]) half[i] = nxt[i];
            has[i]  = 1'b0;
            left[i] = half[i];
         end else if (!en[i]) begin
            if (has[i]) begin
               half[i] = nxt[i];
               has[i]  = 1'b0;
               left[i] = half[i];
            end
         end else begin
            left[i]--;
            if (left[i] == 0) begin
               m_out[i]  = ~m_out[i];
               m_tick[i] = 1'b1;
               if (hit) half[i] = int'(cfg_div);
               else if (has[i]) half[i] = nxt[i];
               has[i]  = 1'b0;
               left[i] = half[i];
               hit     = 1'b0;
            end
         end
         if (hit) begin
            nxt[i] = int'(cfg_div);
            has[i] = 1'b1;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; en = '0; sync_clr = 1'b0; cfg_wr = 1'b0; cfg_ch = '0; cfg_div = '0;
      repeat (3) @(negedge clk);
      if (clk_out !== 4'h0) begin bad++; $display("[TB] FAIL reset clk_out: got %h want 0", clk_out); end
      total++;
      if (tick !== 4'h0) begin bad++; $display("[TB] FAIL reset tick: got %h want 0", tick); end
      total++;
      if (cfg_err !== 1'b0) begin bad++; $display("[TB] FAIL reset cfg_err: got %b want 0", cfg_err); end
      total++;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_free_run();
      en = 4'hF;
      for (int k = 1; k <= 16; k++) begin
         step();
         if ({clk_out, tick, cfg_err} !== {m_out, m_tick, m_err}) begin bad++; $display("[TB] FAIL free_run model k=%0d: got %b want %b", k, {clk_out, tick, cfg_err}, {m_out, m_tick, m_err}); end
         total++;
         if (tick !== ((k % 4 == 0) ? 4'hF : 4'h0)) begin bad++; $display("[TB] FAIL free_run tick k=%0d: got %h", k, tick); end
         total++;
         if (clk_out !== (((k / 4) % 2 == 1) ? 4'hF : 4'h0)) begin bad++; $display("[TB] FAIL free_run clk_out k=%0d: got %h", k, clk_out); end
         total++;
      end
   endtask

   task automatic test_reprogram();
      step();
      if ({clk_out, tick, cfg_err} !== {m_out, m_tick, m_err}) begin bad++; $display("[TB] FAIL reprogram pre: got %b want %b", {clk_out, tick, cfg_err}, {m_out, m_tick, m_err}); end
      total++;
      cfg_wr = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd2;
      for (int k = 0; k < 10; k++) begin
         step();
         cfg_wr = 1'b0;
         if ({clk_out, tick, cfg_err} !== {m_out, m_tick, m_err}) begin bad++; $display("[TB] FAIL reprogram model k=%0d: got %b want %b", k, {clk_out, tick, cfg_err}, {m_out, m_tick, m_err}); end
         total++;
         if (tick[1] !== ((k >= 2) && (k % 2 == 0))) begin bad++; $display("[TB] FAIL reprogram ch1 tick k=%0d: got %b", k, tick[1]); end
         total++;
         if (tick[0] !== ((k == 2) || (k == 6))) begin bad++; $display("[TB] FAIL reprogram ch0 tick k=%0d: got %b", k, tick[0]); end
         total++;
      end
   endtask

   task automatic test_bad_writes();
      logic [2:0] chs  [2] = '{3'd0, 3'd5};
      logic [7:0] divs [2] = '{8'd0, 8'd3};
      for (int w = 0; w < 2; w++) begin
         cfg_wr = 1'b1; cfg_ch = chs[w]; cfg_div = divs[w];
         step();
         cfg_wr = 1'b0;
         if (cfg_err !== 1'b1) begin bad++; $display("[TB] FAIL bad_write err pulse w=%0d: got %b want 1", w, cfg_err); end
         total++;
         step();
         if (cfg_err !== 1'b0) begin bad++; $display("[TB] FAIL bad_write err clear w=%0d: got %b want 0", w, cfg_err); end
         total++;
      end
      for (int k = 0; k < 8; k++) begin
         step();
         if ({clk_out, tick, cfg_err} !== {m_out, m_tick, m_err}) begin bad++; $display("[TB] FAIL bad_write model k=%0d: got %b want %b", k, {clk_out, tick, cfg_err}, {m_out, m_tick, m_err}); end
         total++;
      end
   endtask

   task automatic test_enable_gate();
      int   guard = 0;
      logic held;
      while (left[2] != 2 && guard < 20) begin
         step();
         guard++;
      end
      if (guard >= 20) begin bad++; $display("[TB] FAIL enable wait: ch2 never reached count 2 (left=%0d, required 2)", left[2]); end
      total++;
      en[2] = 1'b0;
      held  = clk_out[2];
      for (int k = 0; k < 10; k++) begin
         step();
         if (clk_out[2] !== held || tick[2] !== 1'b0) begin bad++; $display("[TB] FAIL enable hold k=%0d: got out=%b tick=%b want out=%b tick=0", k, clk_out[2], tick[2], held); end
         total++;
      end
      en[2] = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         if (tick[2] !== (k == 2)) begin bad++; $display("[TB] FAIL enable resume k=%0d: got tick=%b", k, tick[2]); end
         total++;
         if ({clk_out, tick, cfg_err} !== {m_out, m_tick, m_err}) begin bad++; $display("[TB] FAIL enable model k=%0d: got %b want %b", k, {clk_out, tick, cfg_err}, {m_out, m_tick, m_err}); end
         total++;
      end
      en[2] = 1'b0;
      cfg_wr = 1'b1; cfg_ch = 3'd2; cfg_div = 8'd3;
      step();
      cfg_wr = 1'b0;
      step();
      en[2] = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         if (tick[2] !== (k == 3)) begin bad++; $display("[TB] FAIL disabled write k=%0d: got tick=%b", k, tick[2]); end
         total++;
         if ({clk_out, tick, cfg_err} !== {m_out, m_tick, m_err}) begin bad++; $display("[TB] FAIL disabled write model k=%0d: got %b want %b", k, {clk_out, tick, cfg_err}, {m_out, m_tick, m_err}); end
         total++;
      end
   endtask

   task automatic test_sync_clr();
      cfg_wr = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd4;
      step();
      cfg_ch = 3'd2;
      step();
      cfg_wr = 1'b0;
      for (int k = 0; k < 8; k++) begin
         en = 4'($urandom_range(0, 15));
         step();
         if ({clk_out, tick, cfg_err} !== {m_out, m_tick, m_err}) begin bad++; $display("[TB] FAIL sync skew model k=%0d: got %b want %b", k, {clk_out, tick, cfg_err}, {m_out, m_tick, m_err}); end
         total++;
      end
      en = 4'hF; sync_clr = 1'b1;
      step();
      sync_clr = 1'b0;
      if (clk_out !== 4'h0 || tick !== 4'h0) begin bad++; $display("[TB] FAIL sync clear: got out=%h tick=%h want 0 0", clk_out, tick); end
      total++;
      for (int k = 1; k <= 4; k++) begin
         step();
         if (tick !== ((k == 4) ? 4'hF : 4'h0)) begin bad++; $display("[TB] FAIL sync realign k=%0d: got tick=%h", k, tick); end
         total++;
         if ({clk_out, tick, cfg_err} !== {m_out, m_tick, m_err}) begin bad++; $display("[TB] FAIL sync model k=%0d: got %b want %b", k, {clk_out, tick, cfg_err}, {m_out, m_tick, m_err}); end
         total++;
      end
   endtask

   task automatic test_async_reset();
      cfg_wr = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd2;
      step();
      cfg_wr = 1'b0;
      step();
      if (clk_out === 4'h0) begin bad++; $display("[TB] FAIL async precondition: got clk_out=%h want nonzero", clk_out); end
      total++;
      #2 rst = 1'b1;
      #1;
      if ({clk_out, tick, cfg_err} !== 9'b0) begin bad++; $display("[TB] FAIL async drop: got %b want 0", {clk_out, tick, cfg_err}); end
      total++;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int k = 1; k <= 8; k++) begin
         step();
         if (tick !== ((k % 4 == 0) ? 4'hF : 4'h0)) begin bad++; $display("[TB] FAIL post_reset tick k=%0d: got %h", k, tick); end
         total++;
         if ({clk_out, tick, cfg_err} !== {m_out, m_tick, m_err}) begin bad++; $display("[TB] FAIL post_reset model k=%0d: got %b want %b", k, {clk_out, tick, cfg_err}, {m_out, m_tick, m_err}); end
         total++;
      end
   endtask

   task automatic test_div1();
      logic prev;
      cfg_wr = 1'b1; cfg_ch = 3'd3; cfg_div = 8'd1;
      step();
      cfg_wr = 1'b0;
      repeat (5) step();
      prev = clk_out[3];
      for (int k = 0; k < 8; k++) begin
         step();
         if (tick[3] !== 1'b1 || clk_out[3] === prev) begin bad++; $display("[TB] FAIL div1 k=%0d: got tick=%b out=%b want tick=1 out=%b", k, tick[3], clk_out[3], ~prev); end
         total++;
         if ({clk_out, tick, cfg_err} !== {m_out, m_tick, m_err}) begin bad++; $display("[TB] FAIL div1 model k=%0d: got %b want %b", k, {clk_out, tick, cfg_err}, {m_out, m_tick, m_err}); end
         total++;
         prev = clk_out[3];
      end
   endtask

   task automatic test_max_div();
      int n = 0;
      int guard = 0;
      cfg_wr = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd255;
      step();
      cfg_wr = 1'b0;
      while (tick[0] !== 1'b1 && guard < 10) begin
         step();
         guard++;
      end
      do begin
         step();
         n++;
         if ({clk_out, tick, cfg_err} !== {m_out, m_tick, m_err}) begin bad++; $display("[TB] FAIL max_div model n=%0d: got %b want %b", n, {clk_out, tick, cfg_err}, {m_out, m_tick, m_err}); end
         total++;
      end while (tick[0] !== 1'b1 && n < 300);
      if (n != 255) begin bad++; $display("[TB] FAIL max_div half period: got %0d want 255", n); end
      total++;
   endtask

   task automatic test_random();
      for (int k = 0; k < 500; k++) begin
         en       = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         sync_clr = ($urandom_range(0, 39) == 0);
         cfg_wr   = ($urandom_range(0, 7) == 0);
         cfg_ch   = 3'($urandom_range(0, 7));
         cfg_div  = 8'($urandom_range(0, 6));
         step();
         if ({clk_out, tick, cfg_err} !== {m_out, m_tick, m_err}) begin bad++; $display("[TB] FAIL random k=%0d: got %b want %b", k, {clk_out, tick, cfg_err}, {m_out, m_tick, m_err}); end
         total++;
      end
      cfg_wr = 1'b0; sync_clr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_reprogram();
      test_bad_writes();
      test_enable_gate();
      test_sync_clr();
      test_async_reset();
      test_div1();
      test_max_div();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
